// File: rtl/ingress_arbiter_if.sv
// Ingress arbiter handshake bundle: per-port requests, transaction
// status in, grant selection and timeout pulse out.
interface ingress_arbiter_if;
   logic       int_valid0;
   logic       int_valid1;
   logic       int_valid2;
   logic       int_valid3;
   logic       trans_started;
   logic       trans_done;
   logic [1:0] ig_sel;
   logic       grant_active;
   logic [3:0] grant_onehot;
   logic       timeout_err;

   modport master (
      output int_valid0, int_valid1, int_valid2, int_valid3,
      output trans_started, trans_done,
      input  ig_sel, grant_active, grant_onehot, timeout_err
   );

   modport slave (
      input  int_valid0, int_valid1, int_valid2, int_valid3,
      input  trans_started, trans_done,
      output ig_sel, grant_active, grant_onehot, timeout_err
   );
endinterface

// File: rtl/ingress_arbiter.sv
// Round-robin 4-port ingress arbiter with back-to-back re-arbitration.
// Define ARB_TIMEOUT_EN to enable forced release after TIMEOUT_CYCLES.
module ingress_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic         clk,
   input logic         rst,
   ingress_arbiter_if.slave arb
);
   typedef enum logic {IDLE, OWN} state_t;

   state_t     state, state_nx;
   logic [1:0] ig_sel_q, ig_sel_nx;
   logic [1:0] last_grant, last_grant_nx;
   logic [3:0] req;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       any_req;
   logic       abandon;
   logic       timeout_hit;
   logic       release_ev;
   logic       grant_ev;

   assign req = {arb.int_valid3, arb.int_valid2,
                 arb.int_valid1, arb.int_valid0};

   assign abandon = !req[ig_sel_q] && !arb.trans_started;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt, hold_cnt_nx;
   logic       timeout_err_q;

   // trans_done on the limit cycle counts as a normal completion
   assign timeout_hit = (state == OWN) && !arb.trans_done
                     && (hold_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      hold_cnt_nx = hold_cnt;
      if (grant_ev)
         hold_cnt_nx = 8'd0;
      else if (state == OWN && hold_cnt != 8'hff)
         hold_cnt_nx = hold_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt      <= 8'd0;
         timeout_err_q <= 1'b0;
      end else begin
         hold_cnt      <= hold_cnt_nx;
         timeout_err_q <= timeout_hit;
      end
   end

   assign arb.timeout_err = timeout_err_q;
`else
   assign timeout_hit     = 1'b0;
   assign arb.timeout_err = 1'b0;
`endif

   // Search starts just past the last winner; offset 4 wraps onto it
   always_comb begin
      winner  = last_grant;
      any_req = 1'b0;
      idx     = last_grant;
      for (int i = 1; i <= 4; i++) begin
         idx = last_grant + 2'(i);
         if (!any_req && req[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx      = state;
      ig_sel_nx     = ig_sel_q;
      last_grant_nx = last_grant;
      grant_ev      = 1'b0;
      release_ev    = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_nx = OWN;
               grant_ev = 1'b1;
            end
         end
         OWN: begin
            release_ev = arb.trans_done | abandon | timeout_hit;
            if (release_ev) begin
               if (any_req) grant_ev = 1'b1;
               else         state_nx = IDLE;
            end
         end
      endcase
      if (grant_ev) begin
         ig_sel_nx     = winner;
         last_grant_nx = winner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ig_sel_q   <= 2'b00;
         last_grant <= 2'b11;
      end else begin
         state      <= state_nx;
         ig_sel_q   <= ig_sel_nx;
         last_grant <= last_grant_nx;
      end
   end

   assign arb.ig_sel       = ig_sel_q;
   assign arb.grant_active = (state == OWN);
   assign arb.grant_onehot = (state == OWN) ? (4'b0001 << ig_sel_q)
                                            : 4'b0000;
endmodule
